// File: rtl/sha256_digest_unloader_pkg.sv
// sha256_pkg -- shared definitions for the SHA-256 digest unloader.
//   DIGEST_W / WORD_W : digest width and host beat width
//   unload_state_t    : unloader FSM states
//   bswap64           : byte reversal of one 64-bit beat (used when
//                       DIGEST_BSWAP_EN is defined)
package sha256_pkg;

    localparam int DIGEST_W = 256;
    localparam int WORD_W   = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unload_state_t;

    function automatic logic [63:0] bswap64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = x[56-8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_digest_unloader_if.sv
// sha256_digest_unloader_if -- host-side beat stream.
//   data_o  : current beat                (master -> slave)
//   valid_o : data_o/last_o are valid     (master -> slave)
//   last_o  : current beat is the final one of the digest
//   ready_i : sink accepts the beat       (slave -> master)
// Handshake: a beat transfers in any cycle where valid_o and ready_i are
// both 1. Once valid_o rises, data_o/last_o hold and valid_o stays high
// until that transfer happens.
interface sha256_digest_unloader_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              last_o;
    logic              ready_i;

    modport master (output data_o, output valid_o, output last_o, input ready_i);
    modport slave  (input  data_o, input  valid_o, input  last_o, output ready_i);
endinterface

// File: rtl/sha256_digest_unloader_beat_mux.sv
// sha256_beat_mux -- combinational selection of beat idx_i from a
// BEATS*DATA_W source vector, beat 0 taken from the most significant end.
// With DIGEST_BSWAP_EN defined the selected beat is byte-reversed.
//   src_i  : source vector (shadow register or live digest)
//   idx_i  : beat index
//   beat_o : selected (optionally swapped) beat
module sha256_beat_mux
    import sha256_pkg::*;
#(
    parameter int BEATS  = 4,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 2
) (
    input  logic [BEATS*DATA_W-1:0] src_i,
    input  logic [CNT_W-1:0]        idx_i,
    output logic [DATA_W-1:0]       beat_o
);
    logic [DATA_W-1:0] sel;

    always_comb begin
        sel = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (idx_i == CNT_W'(k)) begin
                sel = src_i[(BEATS-1-k)*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DIGEST_BSWAP_EN
    assign beat_o = bswap64(sel);
`else
    assign beat_o = sel;
`endif

endmodule

// File: rtl/sha256_digest_unloader.sv
// sha256_digest_unloader -- captures the 256-bit hash state on start and
// streams it to the host as BEATS registered beats over a valid/ready link.
//   CLK, RST   : clock, asynchronous active-high reset
//   start      : capture strobe, honoured only while busy_o = 0
//   digest_i   : H0..H7, H0 in the top word
//   busy_o     : transfer in progress
//   done_o     : one-cycle pulse after the last beat is accepted
//   state_o    : FSM state (debug)
//   bus        : beat stream (master modport)
// Optional macro DIGEST_BSWAP_EN: byte-reverse each beat on the output path.
module sha256_digest_unloader
    import sha256_pkg::*;
#(
    parameter int BEATS  = 4,
    parameter int DATA_W = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [BEATS*DATA_W-1:0] digest_i,
    output logic                    busy_o,
    output logic                    done_o,
    output unload_state_t           state_o,
    sha256_digest_unloader_if.master bus
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    unload_state_t             state_q, state_d;
    logic [BEATS*DATA_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic                      last_q, last_d;
    logic                      done_q, done_d;

    logic [BEATS*DATA_W-1:0]   mux_src;
    logic [CNT_W-1:0]          mux_idx;
    logic [DATA_W-1:0]         mux_beat;

    // The mux looks one beat ahead so data_o can be registered: in IDLE it
    // prepares beat 0 of the live digest, in SEND the beat after cnt_q.
    always_comb begin
        if (state_q == IDLE) begin
            mux_src = digest_i;
            mux_idx = '0;
        end else begin
            mux_src = shadow_q;
            mux_idx = cnt_q + 1'b1;
        end
    end

    sha256_beat_mux #(
        .BEATS  (BEATS),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_beat_mux (
        .src_i  (mux_src),
        .idx_i  (mux_idx),
        .beat_o (mux_beat)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        last_d   = last_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEND;
                    shadow_d = digest_i;
                    cnt_d    = '0;
                    data_d   = mux_beat;
                    last_d   = (LAST_IDX == '0);
                end
            end
            SEND: begin
                if (bus.ready_i) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        data_d  = '0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        data_d = mux_beat;
                        last_d = ((cnt_q + 1'b1) == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    // valid/busy come straight from the state flop, so nothing on the
    // output side depends combinationally on ready_i.
    assign bus.data_o  = data_q;
    assign bus.valid_o = (state_q == SEND);
    assign bus.last_o  = last_q;
    assign busy_o      = (state_q == SEND);
    assign done_o      = done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_sha256_digest_unloader.sv
module tb_sha256_digest_unloader;
    import sha256_pkg::*;

    localparam logic [255:0] ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic          CLK;
    logic          RST;
    logic          start;
    logic [255:0]  digest_i;
    logic          busy_o;
    logic          done_o;
    unload_state_t state_o;

    sha256_digest_unloader_if bus ();

    sha256_digest_unloader dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .digest_i (digest_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .state_o  (state_o),
        .bus      (bus.master)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- counters / scoreboard ----------------
    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [64:0] exp_q[$];   // {last, data}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] host_order(input logic [63:0] x);
        logic [63:0] r;
`ifdef DIGEST_BSWAP_EN
        for (int i = 0; i < 8; i++) r[8*i +: 8] = x[56-8*i +: 8];
`else
        r = x;
`endif
        return r;
    endfunction

    task automatic push_digest(input logic [255:0] d);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k == 3), host_order(d[255-64*k -: 64])});
        end
    endtask

    function automatic logic [255:0] rand_digest();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // ---------------- monitor ----------------
    logic        stall_prev = 1'b0;
    logic [63:0] hold_data;
    logic        hold_last;

    always @(negedge CLK) begin
        if (RST) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(bus.valid_o), 64'd1);
                check("hold_data", bus.data_o, hold_data);
                check("hold_last", 64'(bus.last_o), 64'(hold_last));
            end
            if (bus.valid_o && bus.ready_i) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", bus.data_o, e[63:0]);
                    check("beat_last", 64'(bus.last_o), 64'(e[64]));
                end
            end
            stall_prev = bus.valid_o && !bus.ready_i;
            hold_data  = bus.data_o;
            hold_last  = bus.last_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [255:0] d);
        digest_i = d;
        push_digest(d);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives ready from a 4-cycle pattern until four beats are accepted;
    // done_o must be high exactly one cycle after the fourth acceptance.
    task automatic drain(input logic [3:0] pat, input string tag);
        int acc;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            bus.ready_i = pat[i % 4];
            @(negedge CLK);
            if (bus.valid_o && bus.ready_i) acc++;
            tick();
            if (acc == 4) begin
                check({tag, "_done"}, 64'(done_o), 64'd1);
                check({tag, "_busy_end"}, 64'(busy_o), 64'd0);
                break;
            end else begin
                check({tag, "_no_done"}, 64'(done_o), 64'd0);
            end
        end
        check({tag, "_beats"}, 64'(acc), 64'd4);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, bus.data_o, 64'd0);
        check({tag, "_valid"}, 64'(bus.valid_o), 64'd0);
        check({tag, "_last"}, 64'(bus.last_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    logic [255:0] d2, d3;

    initial begin
        RST = 1'b1;
        start = 1'b0;
        digest_i = '0;
        bus.ready_i = 1'b0;
        #3;
        check_idle_outputs("rst");
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_state", 64'(state_o), 64'(IDLE));
        tick();
        tick();
        RST = 1'b0;
        tick();

        // S1: full throughput, exact cycle timing
        bus.ready_i = 1'b1;
        do_start(ABC);
        for (int k = 0; k < 4; k++) begin
            check("s1_valid", 64'(bus.valid_o), 64'd1);
            check("s1_busy", 64'(busy_o), 64'd1);
            check("s1_last", 64'(bus.last_o), 64'(k == 3));
            check("s1_no_done", 64'(done_o), 64'd0);
            tick();
        end
        check("s1_done", 64'(done_o), 64'd1);
        check_idle_outputs("s1_end");
        tick();
        check("s1_done_pulse", 64'(done_o), 64'd0);
        tick();

        // S2: stalls 1,0,0,1,...
        do_start(ABC);
        drain(4'b1001, "s2");
        tick();
        check("s2_done_pulse", 64'(done_o), 64'd0);

        // S3: start and digest_i changes during SEND are ignored
        bus.ready_i = 1'b0;
        do_start(ABC);
        tick();
        digest_i = rand_digest();
        start = 1'b1;
        tick();
        start = 1'b0;
        digest_i = rand_digest();
        check("s3_busy", 64'(busy_o), 64'd1);
        drain(4'b0101, "s3");
        tick();

        // S4: reset after beat 1 accepted
        bus.ready_i = 1'b1;
        do_start(ABC);
        tick();
        tick();
        RST = 1'b1;
        #1;
        check_idle_outputs("s4_rst");
        check("s4_rst_done", 64'(done_o), 64'd0);
        check("s4_remaining", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        tick();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("s4_no_done", 64'(done_o), 64'd0);
            check("s4_no_valid", 64'(bus.valid_o), 64'd0);
            tick();
        end
        do_start(ABC);
        drain(4'b1111, "s4r");
        tick();

        // S5: back-to-back start in the done cycle
        d2 = rand_digest();
        d3 = rand_digest();
        do_start(d2);
        drain(4'b1111, "s5a");
        do_start(d3);
        check("s5_b2b_valid", 64'(bus.valid_o), 64'd1);
        check("s5_b2b_busy", 64'(busy_o), 64'd1);
        drain(4'b1111, "s5b");
        tick();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
